// File: rtl/sump_cmd_decoder.sv
// SUMP host byte decoder: assembles 1-byte short and 5-byte long commands from UART bytes,
// strobes each completed command to the controller and aborts stalled or corrupted long commands.
module sump_cmd_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  LONG_MASK      = 8'h80
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_error,
    output logic [7:0]  opcode,
    output logic [31:0] command,
    output logic        cmd_recv_rx,
    output logic        cmd_abort,
    output logic        busy
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Abort is registered, so the decision is taken one cycle before the pulse is due.
    localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT_CYCLES - 2);
    localparam logic [TW-1:0] TIMER_MAX   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        ARG  = 1'b1
    } state_t;

    state_t        r_state;
    logic [1:0]    r_count;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_stageOp;
    logic [31:0]   r_stageArg;
    logic [7:0]    r_opcode;
    logic [31:0]   r_command;
    logic          r_recv;
    logic          r_abort;

    state_t        w_stateNext;
    logic [1:0]    w_countNext;
    logic [TW-1:0] w_timerNext;
    logic [7:0]    w_stageOpNext;
    logic [31:0]   w_stageArgNext;
    logic [7:0]    w_opcodeNext;
    logic [31:0]   w_commandNext;
    logic          w_recvNext;
    logic          w_abortNext;
    logic          w_isLong;

    assign w_isLong = (rx_data & LONG_MASK) != 8'h00;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= 2'd0;
            r_timer    <= '0;
            r_stageOp  <= 8'h00;
            r_stageArg <= 32'h0;
            r_opcode   <= 8'h00;
            r_command  <= 32'h0;
            r_recv     <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_count    <= w_countNext;
            r_timer    <= w_timerNext;
            r_stageOp  <= w_stageOpNext;
            r_stageArg <= w_stageArgNext;
            r_opcode   <= w_opcodeNext;
            r_command  <= w_commandNext;
            r_recv     <= w_recvNext;
            r_abort    <= w_abortNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_countNext    = r_count;
        w_timerNext    = r_timer;
        w_stageOpNext  = r_stageOp;
        w_stageArgNext = r_stageArg;
        w_opcodeNext   = r_opcode;
        w_commandNext  = r_command;
        w_recvNext     = 1'b0;
        w_abortNext    = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_valid && !rx_error) begin
                    if (w_isLong) begin
                        w_stageOpNext  = rx_data;
                        w_stageArgNext = 32'h0;
                        w_countNext    = 2'd0;
                        w_timerNext    = '0;
                        w_stateNext    = ARG;
                    end else begin
                        w_opcodeNext  = rx_data;
                        w_commandNext = 32'h0;
                        w_recvNext    = 1'b1;
                    end
                end
            end
            ARG: begin
                if (rx_valid) begin
                    if (rx_error) begin
                        w_abortNext = 1'b1;
                        w_stateNext = IDLE;
                    end else begin
                        // Argument arrives least-significant byte first.
                        w_stageArgNext[8*r_count +: 8] = rx_data;
                        w_timerNext = '0;
                        w_countNext = r_count + 2'd1;
                        if (r_count == 2'd3) begin
                            w_opcodeNext  = r_stageOp;
                            w_commandNext = w_stageArgNext;
                            w_recvNext    = 1'b1;
                            w_stateNext   = IDLE;
                        end
                    end
                end else if (r_timer == TIMER_LIMIT) begin
                    w_abortNext = 1'b1;
                    w_stateNext = IDLE;
                end else if (r_timer != TIMER_MAX) begin
                    w_timerNext = r_timer + TW'(1);
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    assign opcode      = r_opcode;
    assign command     = r_command;
    assign cmd_recv_rx = r_recv;
    assign cmd_abort   = r_abort;
    assign busy        = (r_state == ARG);

endmodule
